pipe_stage_regs: RTL and testbench

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

---
 rtl/pipe_stage_regs_pkg.sv | 51 +++++
 rtl/pipe_stage_regs_reg.sv | 22 ++
 rtl/pipe_stage_regs.sv | 114 +++++++++++
 tb/tb_pipe_stage_regs.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_regs_pkg.sv
// pipe_stage_regs_pkg: shared reset values, MemtoReg encodings and stage-register bubble bundles
package pipe_stage_regs_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        MTR_ALU   = 2'd0,
        MTR_LOAD  = 2'd1,
        MTR_OTHER = 2'd2
    } mem_to_reg_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic        reg_wr;
        logic        mem_wr;
        logic        use_rt;
        logic        mul;
        logic [1:0]  mem_to_reg;
        logic        valid;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic        reg_wr;
        logic        mem_wr;
        logic        mul;
        logic [1:0]  mem_to_reg;
        logic        valid;
    } ex_mem_t;

    localparam if_id_t  IF_ID_BUBBLE_DEFAULT = '{inst: NOP_INST_DEFAULT, default: '0};
    localparam id_ex_t  ID_EX_BUBBLE  = '{mem_to_reg: MTR_ALU, default: '0};
    localparam ex_mem_t EX_MEM_BUBBLE = '{mem_to_reg: MTR_ALU, default: '0};

endpackage

// File: rtl/pipe_stage_regs_reg.sv
// pipe_reg: one pipeline register with hold (stall) and bubble (flush) control; flush beats stall
module pipe_reg
    import pipe_stage_regs_pkg::*;
#(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // reset and flush both load the bubble value; stall holds, otherwise load
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= RST_VAL;
        else if (flush) q <= RST_VAL;
        else if (!stall) q <= d;

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC, IF/ID, ID/EX and EX/MEM registers with hazard hold/bubble control
// Optional saturating stall/flush counters enabled by macro PIPE_PERF_CNT_EN.
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_PC,
    input  logic        stall_IF_ID,
    input  logic        stall_ID_EX,
    input  logic        flush_IF_ID,
    input  logic        flush_ID_EX,
    input  logic        flush_EX_MEM,
    input  logic [31:0] pc_next,
    input  logic [31:0] inst_IF,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_busA,
    input  logic [31:0] id_busB,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rw,
    input  logic        id_RegWr,
    input  logic        id_MemWr,
    input  logic        id_USE_RT,
    input  logic        id_Mul,
    input  logic [1:0]  id_MemtoReg,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_storeData,
    output logic [31:0] pc,
    output logic [31:0] pc_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic [31:0] pc_EX,
    output logic [31:0] busA_EX,
    output logic [31:0] busB_EX,
    output logic [31:0] imm_EX,
    output logic [4:0]  rs_EX,
    output logic [4:0]  rt_EX,
    output logic [4:0]  rw_EX,
    output logic        RegWr_EX,
    output logic        MemWr_EX,
    output logic        USE_RT_EX,
    output logic        Mul_EX,
    output logic [1:0]  MemtoReg_EX,
    output logic        valid_EX,
    output logic [31:0] result_MEM,
    output logic [31:0] storeData_MEM,
    output logic [4:0]  rt_MEM,
    output logic [4:0]  rw_MEM,
    output logic        RegWr_MEM,
    output logic        MemWr_MEM,
    output logic        Mul_MEM,
    output logic [1:0]  MemtoReg_MEM,
    output logic        valid_MEM,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, default: '0};

    if_id_t  if_id_d,  if_id_q;
    id_ex_t  id_ex_d,  id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;

    assign if_id_d  = '{pc: pc, inst: inst_IF, valid: 1'b1};
    assign id_ex_d  = '{pc: id_pc, bus_a: id_busA, bus_b: id_busB, imm: id_imm,
                        rs: id_rs, rt: id_rt, rw: id_rw, reg_wr: id_RegWr, mem_wr: id_MemWr,
                        use_rt: id_USE_RT, mul: id_Mul, mem_to_reg: id_MemtoReg, valid: if_id_q.valid};
    assign ex_mem_d = '{result: ex_result, store_data: ex_storeData, rt: id_ex_q.rt, rw: id_ex_q.rw,
                        reg_wr: id_ex_q.reg_wr, mem_wr: id_ex_q.mem_wr, mul: id_ex_q.mul,
                        mem_to_reg: id_ex_q.mem_to_reg, valid: id_ex_q.valid};

    pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .stall(stall_PC), .flush(1'b0), .d(pc_next), .q(pc)
    );

    pipe_reg #(.W($bits(if_id_t)), .RST_VAL(IF_ID_BUBBLE)) u_if_id (
        .clk(clk), .rst(rst), .stall(stall_IF_ID), .flush(flush_IF_ID), .d(if_id_d), .q(if_id_q)
    );

    pipe_reg #(.W($bits(id_ex_t)), .RST_VAL(ID_EX_BUBBLE)) u_id_ex (
        .clk(clk), .rst(rst), .stall(stall_ID_EX), .flush(flush_ID_EX), .d(id_ex_d), .q(id_ex_q)
    );

    pipe_reg #(.W($bits(ex_mem_t)), .RST_VAL(EX_MEM_BUBBLE)) u_ex_mem (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(flush_EX_MEM), .d(ex_mem_d), .q(ex_mem_q)
    );

    assign {pc_ID, inst_ID, valid_ID} = if_id_q;
    assign {pc_EX, busA_EX, busB_EX, imm_EX, rs_EX, rt_EX, rw_EX, RegWr_EX, MemWr_EX,
            USE_RT_EX, Mul_EX, MemtoReg_EX, valid_EX} = id_ex_q;
    assign {result_MEM, storeData_MEM, rt_MEM, rw_MEM, RegWr_MEM, MemWr_MEM,
            Mul_MEM, MemtoReg_MEM, valid_MEM} = ex_mem_q;

`ifdef PIPE_PERF_CNT_EN
    // saturating counts of stalled cycles and of cycles with any flush
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_PC && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if ((flush_IF_ID || flush_ID_EX || flush_EX_MEM) && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: directed, table-driven and random checks of pipe_stage_regs against a stage model
module tb_pipe_stage_regs;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_PC, stall_IF_ID, stall_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM;
    logic [31:0] pc_next, inst_IF, id_pc, id_busA, id_busB, id_imm, ex_result, ex_storeData;
    logic [4:0]  id_rs, id_rt, id_rw;
    logic        id_RegWr, id_MemWr, id_USE_RT, id_Mul;
    logic [1:0]  id_MemtoReg;
    logic [31:0] pc, pc_ID, inst_ID, pc_EX, busA_EX, busB_EX, imm_EX, result_MEM, storeData_MEM;
    logic        valid_ID, RegWr_EX, MemWr_EX, USE_RT_EX, Mul_EX, valid_EX;
    logic [4:0]  rs_EX, rt_EX, rw_EX, rt_MEM, rw_MEM;
    logic [1:0]  MemtoReg_EX, MemtoReg_MEM;
    logic        RegWr_MEM, MemWr_MEM, Mul_MEM, valid_MEM;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_regs dut (
        .clk(clk), .rst(rst),
        .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .pc_next(pc_next), .inst_IF(inst_IF),
        .id_pc(id_pc), .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rw(id_rw),
        .id_RegWr(id_RegWr), .id_MemWr(id_MemWr), .id_USE_RT(id_USE_RT), .id_Mul(id_Mul),
        .id_MemtoReg(id_MemtoReg), .ex_result(ex_result), .ex_storeData(ex_storeData),
        .pc(pc), .pc_ID(pc_ID), .inst_ID(inst_ID), .valid_ID(valid_ID),
        .pc_EX(pc_EX), .busA_EX(busA_EX), .busB_EX(busB_EX), .imm_EX(imm_EX),
        .rs_EX(rs_EX), .rt_EX(rt_EX), .rw_EX(rw_EX),
        .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX), .USE_RT_EX(USE_RT_EX), .Mul_EX(Mul_EX),
        .MemtoReg_EX(MemtoReg_EX), .valid_EX(valid_EX),
        .result_MEM(result_MEM), .storeData_MEM(storeData_MEM), .rt_MEM(rt_MEM), .rw_MEM(rw_MEM),
        .RegWr_MEM(RegWr_MEM), .MemWr_MEM(MemWr_MEM), .Mul_MEM(Mul_MEM),
        .MemtoReg_MEM(MemtoReg_MEM), .valid_MEM(valid_MEM),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [31:0] pc, inst;
        logic        v;
    } m_if_t;

    typedef struct packed {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, rw;
        logic        regwr, memwr, use_rt, mul;
        logic [1:0]  m2r;
        logic        v;
    } m_ex_t;

    typedef struct packed {
        logic [31:0] res, sd;
        logic [4:0]  rt, rw;
        logic        regwr, memwr, mul;
        logic [1:0]  m2r;
        logic        v;
    } m_mem_t;

    typedef struct {
        logic [5:0] ctl;
        logic       ev_id, ev_ex, ev_mem;
        string      name;
    } vec_t;

    logic [31:0] m_pc, m_sc, m_fc;
    m_if_t       m_if;
    m_ex_t       m_ex;
    m_mem_t      m_mem;
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0000_3000;
        m_if  = '0;
        m_ex  = '0;
        m_mem = '0;
        m_sc  = '0;
        m_fc  = '0;
    endtask

    // one clock edge of the pipeline: each register takes the value its upstream held before the edge
    task automatic model_edge();
        m_mem = flush_EX_MEM ? '0 : '{res: ex_result, sd: ex_storeData, rt: m_ex.rt, rw: m_ex.rw,
                  regwr: m_ex.regwr, memwr: m_ex.memwr, mul: m_ex.mul, m2r: m_ex.m2r, v: m_ex.v};
        if (flush_ID_EX) m_ex = '0;
        else if (!stall_ID_EX)
            m_ex = '{pc: id_pc, a: id_busA, b: id_busB, imm: id_imm, rs: id_rs, rt: id_rt, rw: id_rw,
                     regwr: id_RegWr, memwr: id_MemWr, use_rt: id_USE_RT, mul: id_Mul,
                     m2r: id_MemtoReg, v: m_if.v};
        if (flush_IF_ID) m_if = '0;
        else if (!stall_IF_ID) m_if = '{pc: m_pc, inst: inst_IF, v: 1'b1};
        if (!stall_PC) m_pc = pc_next;
        if (PERF) begin
            if (stall_PC && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if ((flush_IF_ID || flush_ID_EX || flush_EX_MEM) && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".if_id"}, {pc_ID, inst_ID, valid_ID}, m_if);
        chk({tag, ".id_ex"}, {pc_EX, busA_EX, busB_EX, imm_EX, rs_EX, rt_EX, rw_EX, RegWr_EX,
                              MemWr_EX, USE_RT_EX, Mul_EX, MemtoReg_EX, valid_EX}, m_ex);
        chk({tag, ".ex_mem"}, {result_MEM, storeData_MEM, rt_MEM, rw_MEM, RegWr_MEM, MemWr_MEM,
                               Mul_MEM, MemtoReg_MEM, valid_MEM}, m_mem);
        chk({tag, ".stall_cnt"}, stall_cnt, m_sc);
        chk({tag, ".flush_cnt"}, flush_cnt, m_fc);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic set_ctl(input logic [5:0] c);
        {stall_PC, stall_IF_ID, stall_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM} = c;
    endtask

    task automatic rand_data();
        pc_next      = $urandom;
        inst_IF      = $urandom;
        id_pc        = $urandom;
        id_busA      = $urandom;
        id_busB      = $urandom;
        id_imm       = $urandom;
        id_rs        = 5'($urandom);
        id_rt        = 5'($urandom);
        id_rw        = 5'($urandom);
        {id_RegWr, id_MemWr, id_USE_RT, id_Mul} = 4'($urandom);
        id_MemtoReg  = 2'($urandom_range(2));
        ex_result    = $urandom;
        ex_storeData = $urandom;
    endtask

    initial begin
        vecs[0] = '{6'b000000, 1'b1, 1'b1, 1'b1, "normal"};
        vecs[1] = '{6'b111001, 1'b1, 1'b1, 1'b0, "load_use"};
        vecs[2] = '{6'b000110, 1'b0, 1'b0, 1'b1, "branch"};
        vecs[3] = '{6'b000100, 1'b0, 1'b1, 1'b1, "jump"};
        vecs[4] = '{6'b001010, 1'b1, 1'b0, 1'b1, "stall_flush_id_ex"};
        vecs[5] = '{6'b111111, 1'b0, 1'b0, 1'b0, "flush_over_stall"};
        vecs[6] = '{6'b001000, 1'b1, 1'b1, 1'b1, "hold_id_ex"};

        rst = 1'b1;
        set_ctl(6'b0);
        rand_data();
        #2;
        model_reset();
        check_model("reset");
        chk("reset.pc", pc, 32'h0000_3000);
        chk("reset.inst_ID", inst_ID, 32'h0);
        chk("reset.valids", {valid_ID, valid_EX, valid_MEM}, 3'b000);

        @(negedge clk);
        pc_next = 32'h0000_3004;
        rst = 1'b0;
        step("release");
        chk("release.pc", pc, 32'h0000_3004);

        rand_data();
        pc_next = 32'h100;
        id_rw = 5'd5;
        id_RegWr = 1'b1;
        step("lu_load");
        chk("lu_load.rw_EX", rw_EX, 5'd5);
        pc_next = 32'h200;
        id_rw = 5'd7;
        set_ctl(6'b111001);
        step("lu_stall");
        chk("lu_stall.pc", pc, 32'h100);
        chk("lu_stall.rw_EX", rw_EX, 5'd5);
        chk("lu_stall.valid_MEM", valid_MEM, 1'b0);
        chk("lu_stall.RegWr_MEM", RegWr_MEM, 1'b0);
        set_ctl(6'b0);
        step("lu_resume");
        chk("lu_resume.rw_MEM", rw_MEM, 5'd5);
        chk("lu_resume.RegWr_MEM", RegWr_MEM, 1'b1);
        chk("lu_resume.valid_MEM", valid_MEM, 1'b1);
        chk("lu_resume.pc", pc, 32'h200);

        inst_IF = 32'h2008_0001;
        pc_next = 32'h500;
        set_ctl(6'b000110);
        step("branch");
        chk("branch.inst_ID", inst_ID, 32'h0);
        chk("branch.valid_ID", valid_ID, 1'b0);
        chk("branch.valid_EX", valid_EX, 1'b0);
        chk("branch.pc", pc, 32'h500);
        set_ctl(6'b0);
        step("branch_after");
        chk("branch_after.valid_ID", valid_ID, 1'b1);
        chk("branch_after.inst_ID", inst_ID, 32'h2008_0001);

        set_ctl(6'b001010);
        step("sf_id_ex");
        chk("sf_id_ex.valid_EX", valid_EX, 1'b0);
        chk("sf_id_ex.rw_EX", rw_EX, 5'd0);
        set_ctl(6'b0);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 3; k++) begin
                rand_data();
                step("warmup");
            end
            rand_data();
            set_ctl(vecs[i].ctl);
            step(vecs[i].name);
            chk({vecs[i].name, ".valids"}, {valid_ID, valid_EX, valid_MEM},
                {vecs[i].ev_id, vecs[i].ev_ex, vecs[i].ev_mem});
            set_ctl(6'b0);
        end

        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_ctl(6'b111000);
        for (int k = 0; k < 3; k++) begin
            rand_data();
            step("midstall");
        end
        chk("midstall.stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
        rst = 1'b1;
        #1;
        model_reset();
        check_model("midstall_rst");
        chk("midstall_rst.stall_cnt", stall_cnt, 32'd0);
        chk("midstall_rst.valids", {valid_ID, valid_EX, valid_MEM}, 3'b000);
        chk("midstall_rst.pc", pc, 32'h0000_3000);
        @(negedge clk);
        set_ctl(6'b0);
        pc_next = 32'h4000;
        rst = 1'b0;
        step("post_rst");
        chk("post_rst.pc", pc, 32'h4000);
        chk("post_rst.valid_ID", valid_ID, 1'b1);

        for (int i = 0; i < 400; i++) begin
            rand_data();
            set_ctl({$urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                     $urandom_range(4) == 0, $urandom_range(4) == 0, $urandom_range(4) == 0});
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
